// File: rtl/sap_microsequencer_if.sv
// Sequencer boundary bundle: IR/flags inputs, host programming handshake,
// debug controls, and the datapath control word / status outputs.
interface sap_microsequencer_if #(
    parameter int OPCODE_W = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero_flag;
    logic                carry_flag;
    logic                prog_mode;
    logic                prog_valid;
    logic                prog_ready;
    logic                prog_done;
    logic                step_mode;
    logic                step;
    logic                resume;
    logic [17:0]         ctrl;
    logic [3:0]          state;
    logic                halted;
    logic                fetch_start;

    // Environment side: IR/flags, host and debug drive the sequencer.
    modport master (
        output opcode, zero_flag, carry_flag,
        output prog_mode, prog_valid, step_mode, step, resume,
        input  prog_ready, prog_done, ctrl, state, halted, fetch_start
    );

    // Sequencer side.
    modport slave (
        input  opcode, zero_flag, carry_flag,
        input  prog_mode, prog_valid, step_mode, step, resume,
        output prog_ready, prog_done, ctrl, state, halted, fetch_start
    );
endinterface

// File: rtl/sap_microsequencer.sv
// Variable-length SAP micro-sequencer. Each instruction returns to T0 (or
// to the step/programming waits) right after its last micro-op. All outputs
// are combinational decodes of the state register, opcode and flags.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | after reset, nothing driven
// T0..T2    | fetch: PC->MAR, PC++, RAM->IR
// E0..E2    | execute micro-ops, length depends on opcode
// HALT      | stopped after HLT, waits for resume
// STEP_WAIT | single-step pause before a fetch
// P_WAIT    | programming mode, ready for a host address/data pair
// P_ADDR    | ui bus -> MAR address
// P_DATA    | ui bus -> MAR data
// P_WRITE   | RAM write, prog_done pulse
// P_EXIT    | clear PC, then instruction boundary
module sap_microsequencer #(
    parameter int OPCODE_W = 4,
    parameter bit EN_JCOND = 1'b1,
    parameter bit EN_STEP  = 1'b1,
    parameter bit EN_PROG  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    sap_microsequencer_if.slave  bus
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_T0        = 4'd1;
    localparam logic [3:0] S_T1        = 4'd2;
    localparam logic [3:0] S_T2        = 4'd3;
    localparam logic [3:0] S_E0        = 4'd4;
    localparam logic [3:0] S_E1        = 4'd5;
    localparam logic [3:0] S_E2        = 4'd6;
    localparam logic [3:0] S_HALT      = 4'd7;
    localparam logic [3:0] S_STEP_WAIT = 4'd8;
    localparam logic [3:0] S_P_WAIT    = 4'd9;
    localparam logic [3:0] S_P_ADDR    = 4'd10;
    localparam logic [3:0] S_P_DATA    = 4'd11;
    localparam logic [3:0] S_P_WRITE   = 4'd12;
    localparam logic [3:0] S_P_EXIT    = 4'd13;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_NOP = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_LDA = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_STA = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;

    localparam int C_OUT_LOAD      = 0;
    localparam int C_REGB_LOAD     = 1;
    localparam int C_ALU_EN        = 2;
    localparam int C_ALU_SUB       = 3;
    localparam int C_REGA_EN       = 4;
    localparam int C_REGA_LOAD     = 5;
    localparam int C_IR_EN         = 6;
    localparam int C_IR_LOAD       = 7;
    localparam int C_RAM_WE        = 8;
    localparam int C_RAM_EN        = 9;
    localparam int C_MAR_DATA_LOAD = 10;
    localparam int C_MAR_ADDR_LOAD = 11;
    localparam int C_PC_LOAD       = 12;
    localparam int C_PC_EN         = 13;
    localparam int C_PC_INC        = 14;
    localparam int C_UI_EN         = 15;
    localparam int C_FLAGS_LOAD    = 16;
    localparam int C_PC_CLR        = 17;

    logic [3:0]  state_q;
    logic [3:0]  state_d;
    logic [3:0]  op_raw;
    logic [3:0]  op;
    logic        step_mode_i;
    logic        prog_mode_i;
    logic [3:0]  boundary_st;
    logic [17:0] ctrl_d;

    // Opcodes wider than 4 bits with any upper bit set decode as NOP.
    generate
        if (OPCODE_W > 4) begin : g_op_wide
            assign op_raw = (|bus.opcode[OPCODE_W-1:4]) ? OP_NOP : bus.opcode[3:0];
        end else if (OPCODE_W == 4) begin : g_op_exact
            assign op_raw = bus.opcode;
        end else begin : g_op_narrow
            assign op_raw = {{(4-OPCODE_W){1'b0}}, bus.opcode};
        end
    endgenerate

    assign op = (!EN_JCOND && (op_raw == OP_JZ || op_raw == OP_JC)) ? OP_NOP : op_raw;

    assign step_mode_i = EN_STEP ? bus.step_mode : 1'b0;
    assign prog_mode_i = EN_PROG ? bus.prog_mode : 1'b0;

    // Where to go at an instruction boundary: programming beats stepping.
    always_comb begin
        boundary_st = S_T0;
        if (prog_mode_i)
            boundary_st = S_P_WAIT;
        else if (step_mode_i)
            boundary_st = S_STEP_WAIT;
    end

    // Next-state decode.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = boundary_st;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_E0;
            S_E0: begin
                case (op)
                    OP_ADD, OP_SUB, OP_LDA, OP_STA: state_d = S_E1;
                    OP_HLT:                         state_d = S_HALT;
                    default:                        state_d = boundary_st;
                endcase
            end
            S_E1: begin
                case (op)
                    OP_ADD, OP_SUB, OP_STA: state_d = S_E2;
                    default:                state_d = boundary_st;
                endcase
            end
            S_E2:    state_d = boundary_st;
            S_HALT:  state_d = bus.resume ? boundary_st : S_HALT;
            S_STEP_WAIT: begin
                if (prog_mode_i)
                    state_d = S_P_WAIT;
                else if (bus.step || !step_mode_i)
                    state_d = S_T0;
                else
                    state_d = S_STEP_WAIT;
            end
            S_P_WAIT: begin
                // A pending write takes precedence over leaving programming mode.
                if (bus.prog_valid)
                    state_d = S_P_ADDR;
                else if (!prog_mode_i)
                    state_d = S_P_EXIT;
                else
                    state_d = S_P_WAIT;
            end
            S_P_ADDR:  state_d = S_P_DATA;
            S_P_DATA:  state_d = S_P_WRITE;
            S_P_WRITE: state_d = S_P_WAIT;
            S_P_EXIT:  state_d = boundary_st;
            default:   state_d = S_IDLE;
        endcase
    end

    // Control word decode.
    always_comb begin
        ctrl_d = '0;
        case (state_q)
            S_T0: begin
                ctrl_d[C_PC_EN]         = 1'b1;
                ctrl_d[C_MAR_ADDR_LOAD] = 1'b1;
            end
            S_T1: ctrl_d[C_PC_INC] = 1'b1;
            S_T2: begin
                ctrl_d[C_RAM_EN]  = 1'b1;
                ctrl_d[C_IR_LOAD] = 1'b1;
            end
            S_E0: begin
                case (op)
                    OP_ADD, OP_SUB, OP_LDA, OP_STA: begin
                        ctrl_d[C_IR_EN]         = 1'b1;
                        ctrl_d[C_MAR_ADDR_LOAD] = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl_d[C_REGA_EN]  = 1'b1;
                        ctrl_d[C_OUT_LOAD] = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_d[C_IR_EN]   = 1'b1;
                        ctrl_d[C_PC_LOAD] = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl_d[C_IR_EN]   = bus.zero_flag;
                        ctrl_d[C_PC_LOAD] = bus.zero_flag;
                    end
                    OP_JC: begin
                        ctrl_d[C_IR_EN]   = bus.carry_flag;
                        ctrl_d[C_PC_LOAD] = bus.carry_flag;
                    end
                    OP_LDI: begin
                        ctrl_d[C_IR_EN]     = 1'b1;
                        ctrl_d[C_REGA_LOAD] = 1'b1;
                    end
                    default: ctrl_d = '0;
                endcase
            end
            S_E1: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        ctrl_d[C_RAM_EN]    = 1'b1;
                        ctrl_d[C_REGB_LOAD] = 1'b1;
                    end
                    OP_LDA: begin
                        ctrl_d[C_RAM_EN]    = 1'b1;
                        ctrl_d[C_REGA_LOAD] = 1'b1;
                    end
                    OP_STA: begin
                        ctrl_d[C_REGA_EN]       = 1'b1;
                        ctrl_d[C_MAR_DATA_LOAD] = 1'b1;
                    end
                    default: ctrl_d = '0;
                endcase
            end
            S_E2: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        ctrl_d[C_ALU_EN]     = 1'b1;
                        ctrl_d[C_ALU_SUB]    = (op == OP_SUB);
                        ctrl_d[C_REGA_LOAD]  = 1'b1;
                        ctrl_d[C_FLAGS_LOAD] = 1'b1;
                    end
                    OP_STA:  ctrl_d[C_RAM_WE] = 1'b1;
                    default: ctrl_d = '0;
                endcase
            end
            S_P_ADDR: begin
                ctrl_d[C_UI_EN]         = 1'b1;
                ctrl_d[C_MAR_ADDR_LOAD] = 1'b1;
            end
            S_P_DATA: begin
                ctrl_d[C_UI_EN]         = 1'b1;
                ctrl_d[C_MAR_DATA_LOAD] = 1'b1;
            end
            S_P_WRITE: ctrl_d[C_RAM_WE] = 1'b1;
            S_P_EXIT:  ctrl_d[C_PC_CLR] = 1'b1;
            default:   ctrl_d = '0;
        endcase
    end

    // State register; reset aborts any instruction or write in flight.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    assign bus.ctrl        = ctrl_d;
    assign bus.state       = state_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fetch_start = (state_q == S_T0);
    assign bus.prog_ready  = EN_PROG && (state_q == S_P_WAIT);
    assign bus.prog_done   = EN_PROG && (state_q == S_P_WRITE);

endmodule

// File: doc/sap_microsequencer.md
Name: sap_microsequencer

Overview:
- Parametrised, single-edge successor to the SAP-style control unit.
- Sequences fetch/execute micro-operations as a variable-length state machine: each instruction returns to T0 as soon as its last micro-op completes, with no fixed six-stage ring.
- Adds conditional jumps, load-immediate, single-step debug, halt/resume, and a handshaked host programming mode.
- Drives the datapath control word; sits between the IR/flags register and the bus/RAM/register blocks.

Parameters:
- OPCODE_W, 4: opcode width. Codes with any bit above bit 3 set decode as NOP.
- EN_JCOND, 1: 1 enables JZ/JC; 0 decodes them as NOP.
- EN_STEP, 1: 0 ties step_mode off internally.
- EN_PROG, 1: 0 ties prog_mode off internally; prog_ready and prog_done stay 0.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  IR opcode field; valid from E0 onward.
- zero_flag  in  1  ALU zero flag (registered in datapath).
- carry_flag  in  1  ALU carry flag.
- prog_mode  in  1  level: enter/stay in programming mode at instruction boundaries.
- prog_valid  in  1  host has an address/data pair on ui bus.
- prog_ready  out  1  high in P_WAIT only.
- prog_done  out  1  one-cycle pulse in P_WRITE.
- step_mode  in  1  level: pause before every fetch.
- step  in  1  one-cycle pulse: release one instruction.
- resume  in  1  one-cycle pulse: leave HALT.
- ctrl  out  18  control word, all bits active-high:
  - 0 out_load, 1 regb_load, 2 alu_en, 3 alu_sub, 4 rega_en, 5 rega_load
  - 6 ir_en, 7 ir_load, 8 ram_we, 9 ram_en, 10 mar_data_load, 11 mar_addr_load
  - 12 pc_load, 13 pc_en, 14 pc_inc, 15 ui_en, 16 flags_load, 17 pc_clr
- state  out  4  current state code.
- halted  out  1  high in HALT.
- fetch_start  out  1  high in T0.

Behaviour:
- State codes:
  - IDLE=0, T0=1, T1=2, T2=3, E0=4, E1=5, E2=6, HALT=7, STEP_WAIT=8
  - P_WAIT=9, P_ADDR=10, P_DATA=11, P_WRITE=12, P_EXIT=13
  - Codes 14–15 are illegal; they go to IDLE on the next edge.
- All outputs are combinational decodes of the state register, opcode and flags. No negedge logic.
- Reset: state<=IDLE. In IDLE, ctrl=0 and all status outputs are 0. Reset mid-instruction or mid-programming aborts with no further ctrl assertion after the edge.
- Boundary rule, applied from IDLE, from the last micro-op of any instruction, and from P_EXIT. Priority order:
  - prog_mode → P_WAIT
  - else step_mode → STEP_WAIT
  - else → T0
- Fetch:
  - T0: pc_en, mar_addr_load.
  - T1: pc_inc.
  - T2: ram_en, ir_load.
- Execute, by opcode (0 HLT, 1 NOP, 2 ADD, 3 SUB, 4 LDA, 5 OUT, 6 STA, 7 JMP, 8 JZ, 9 JC, A LDI, B–F NOP):
  - E0:
    - ADD/SUB/LDA/STA: ir_en, mar_addr_load → E1.
    - OUT: rega_en, out_load → boundary.
    - JMP: ir_en, pc_load → boundary.
    - JZ: ir_en and pc_load only if zero_flag=1 → boundary.
    - JC: same as JZ, gated by carry_flag.
    - LDI: ir_en, rega_load → boundary.
    - NOP: ctrl=0 → boundary.
    - HLT: ctrl=0 → HALT.
  - E1:
    - ADD/SUB: ram_en, regb_load → E2.
    - LDA: ram_en, rega_load → boundary.
    - STA: rega_en, mar_data_load → E2.
  - E2:
    - ADD: alu_en, rega_load, flags_load.
    - SUB: ADD signals plus alu_sub.
    - STA: ram_we.
    - All → boundary.
- Instruction lengths in cycles: NOP/OUT/JMP/JZ/JC/LDI = 4, LDA = 5, ADD/SUB/STA = 6, HLT = 4 then HALT.
- HALT: ctrl=0, halted=1.
  - resume → boundary; the PC already points past HLT.
  - HALT ignores step and prog_mode; only reset or resume exits.
- STEP_WAIT: ctrl=0.
  - step → T0.
  - If prog_mode rises while waiting → P_WAIT (prog_mode priority).
  - Deasserting step_mode without a step pulse → T0.
- Programming:
  - P_WAIT: prog_ready=1.
    - prog_valid → P_ADDR.
    - prog_mode=0 → P_EXIT.
    - prog_valid and prog_mode=0 together: the write wins.
  - P_ADDR: ui_en, mar_addr_load.
  - P_DATA: ui_en, mar_data_load.
  - P_WRITE: ram_we, prog_done=1 → P_WAIT.
  - P_EXIT: pc_clr → boundary.
  - prog_mode is sampled only at boundaries and in P_WAIT. A write in flight always completes.
- step/resume pulses arriving in any other state are ignored (not latched).

Test Plan:
- Reset 2 cycles, then run LDA 9 (mem[9]=0x1C), OUT, HLT:
  - state sequence IDLE,T0,T1,T2,E0,E1,T0…
  - rega_load in LDA's E1; out_load in OUT's E0
  - halted=1 exactly 4 cycles after HLT's T0
- ADD then SUB, each exactly 6 cycles:
  - SUB E2 ctrl = alu_en|alu_sub|rega_load|flags_load = 0x1002C
  - ADD E2 ctrl = 0x10024
- JZ with zero_flag=0 → E0 ctrl=0; with zero_flag=1 → E0 ctrl=0x1040 (pc_load|ir_en). Repeat with EN_JCOND=0 → ctrl=0 in both cases.
- Programming, prog_mode=1, three prog_valid pulses:
  - each write walks P_ADDR, P_DATA, P_WRITE
  - exactly 3 prog_done pulses; ui_en high in P_ADDR/P_DATA only
  - drop prog_mode → pc_clr for one cycle, then T0
- step_mode=1:
  - sequencer parks in STEP_WAIT with ctrl=0
  - each step pulse runs exactly one instruction and returns to STEP_WAIT
  - HALT ignores step; resume exits to STEP_WAIT
- Assert reset in E1 of STA → ram_we is never asserted; state=IDLE and ctrl=0 after the edge.
